// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for a single-cycle-latency instruction BRAM.
// Issues fetch PCs, tags returning words with their PC and absorbs stalls in a one-entry buffer.
module fetch_ctrl #(
   parameter int unsigned         PC_WIDTH    = 32,
   parameter int unsigned         INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [PC_WIDTH-1:0] PC_STEP     = PC_WIDTH'(4)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   work_ena,
   input  logic                   stall,
   input  logic                   pc_jump,
   input  logic [PC_WIDTH-1:0]    pc_target,
   output logic                   imem_en,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_dout,
   output logic                   instr_valid,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic [PC_WIDTH-1:0]    pc_o,
   output logic [1:0]             state_o
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StHold = 2'd2
   } state_e;

   state_e                 r_state, w_state_nxt;
   logic [PC_WIDTH-1:0]    r_fetch_pc, w_fetch_pc_nxt;
   logic                   r_inflight, w_inflight_nxt;
   logic [PC_WIDTH-1:0]    r_req_pc, w_req_pc_nxt;
   logic                   r_hold_valid, w_hold_valid_nxt;
   logic [INSTR_WIDTH-1:0] r_hold_instr, w_hold_instr_nxt;
   logic [PC_WIDTH-1:0]    r_hold_pc, w_hold_pc_nxt;

   logic                   w_active;
   logic                   w_issue;
   logic                   w_kill;
   logic [PC_WIDTH-1:0]    w_addr;

   assign w_active  = (r_state != StIdle);
   assign w_issue   = work_ena && w_active && (pc_jump || !stall);
   assign w_addr    = pc_jump ? pc_target : r_fetch_pc;
   assign w_kill    = !work_ena || (pc_jump && w_active);
   assign imem_en   = w_issue;
   assign imem_addr = w_addr;
   assign state_o   = r_state;

   // Held entry takes precedence: while it is valid nothing is in flight.
   always_comb begin
      instr_valid = 1'b0;
      instr_o     = '0;
      pc_o        = '0;
      if (!w_kill) begin
         if (r_hold_valid) begin
            instr_valid = 1'b1;
            instr_o     = r_hold_instr;
            pc_o        = r_hold_pc;
         end else if (r_inflight) begin
            instr_valid = 1'b1;
            instr_o     = imem_dout;
            pc_o        = r_req_pc;
         end
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_fetch_pc_nxt   = r_fetch_pc;
      w_inflight_nxt   = 1'b0;
      w_req_pc_nxt     = r_req_pc;
      w_hold_valid_nxt = r_hold_valid;
      w_hold_instr_nxt = r_hold_instr;
      w_hold_pc_nxt    = r_hold_pc;
      if (!work_ena) begin
         w_state_nxt      = StIdle;
         w_fetch_pc_nxt   = RESET_PC;
         w_hold_valid_nxt = 1'b0;
      end else begin
         unique case (r_state)
            StIdle: w_state_nxt = StRun;
            StRun, StHold: begin
               if (pc_jump || !stall) begin
                  w_hold_valid_nxt = 1'b0;
                  w_state_nxt      = StRun;
               end else if (r_state == StRun && r_inflight) begin
                  w_hold_valid_nxt = 1'b1;
                  w_hold_instr_nxt = imem_dout;
                  w_hold_pc_nxt    = r_req_pc;
                  w_state_nxt      = StHold;
               end
            end
            default: w_state_nxt = StIdle;
         endcase
         if (w_issue) begin
            w_req_pc_nxt   = w_addr;
            w_inflight_nxt = 1'b1;
            w_fetch_pc_nxt = w_addr + PC_STEP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_fetch_pc   <= RESET_PC;
         r_inflight   <= 1'b0;
         r_req_pc     <= '0;
         r_hold_valid <= 1'b0;
         r_hold_instr <= '0;
         r_hold_pc    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_fetch_pc   <= w_fetch_pc_nxt;
         r_inflight   <= w_inflight_nxt;
         r_req_pc     <= w_req_pc_nxt;
         r_hold_valid <= w_hold_valid_nxt;
         r_hold_instr <= w_hold_instr_nxt;
         r_hold_pc    <= w_hold_pc_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic against a stream-level model.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, work_ena, stall, pc_jump;
   logic [31:0] pc_target;
   logic        imem_en, instr_valid;
   logic [31:0] imem_addr, imem_dout, instr_o, pc_o;
   logic [1:0]  state_o;

   logic        rst8, work8, stall8, jump8;
   logic [7:0]  target8, addr8, pc8;
   logic        en8, valid8;
   logic [31:0] dout8, instr8;
   logic [1:0]  state8;

   int n_checks = 0;
   int n_errors = 0;

   // Model: the word currently presented downstream and where the next fetch goes.
   bit          m_en, m_have, m_held;
   logic [31:0] m_pc, m_next_pc;

   always #5 clk = ~clk;

   fetch_ctrl u_dut (
      .clk        (clk),
      .rst        (rst),
      .work_ena   (work_ena),
      .stall      (stall),
      .pc_jump    (pc_jump),
      .pc_target  (pc_target),
      .imem_en    (imem_en),
      .imem_addr  (imem_addr),
      .imem_dout  (imem_dout),
      .instr_valid(instr_valid),
      .instr_o    (instr_o),
      .pc_o       (pc_o),
      .state_o    (state_o)
   );

   fetch_ctrl #(.PC_WIDTH(8)) u_dut8 (
      .clk        (clk),
      .rst        (rst8),
      .work_ena   (work8),
      .stall      (stall8),
      .pc_jump    (jump8),
      .pc_target  (target8),
      .imem_en    (en8),
      .imem_addr  (addr8),
      .imem_dout  (dout8),
      .instr_valid(valid8),
      .instr_o    (instr8),
      .pc_o       (pc8),
      .state_o    (state8)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   always @(posedge clk) begin
      if (imem_en) imem_dout <= mem_word(imem_addr);
      if (en8)     dout8     <= mem_word({24'h0, addr8});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 0; m_have = 0; m_held = 0; m_pc = '0; m_next_pc = '0;
   endtask

   // Compare every output of the main DUT against the model for the current inputs.
   task automatic check_all(input string tag);
      bit          kill, ev, een;
      logic [31:0] eaddr;
      kill  = !work_ena || (pc_jump && m_en);
      ev    = m_have && !kill;
      een   = work_ena && m_en && (pc_jump || !stall);
      eaddr = pc_jump ? pc_target : m_next_pc;
      chk({tag, ".valid"}, instr_valid, ev);
      chk({tag, ".pc"},    pc_o,        ev ? m_pc : 32'h0);
      chk({tag, ".instr"}, instr_o,     ev ? mem_word(m_pc) : 32'h0);
      chk({tag, ".en"},    imem_en,     een);
      chk({tag, ".addr"},  imem_addr,   eaddr);
      chk({tag, ".state"}, state_o,     !m_en ? 2'd0 : (m_held ? 2'd2 : 2'd1));
   endtask

   task automatic model_update();
      bit een;
      een = work_ena && m_en && (pc_jump || !stall);
      if (!rst) begin
         model_reset();
      end else if (!work_ena) begin
         m_en = 0; m_have = 0; m_held = 0; m_next_pc = '0;
      end else if (!m_en) begin
         m_en = 1;
      end else if (een) begin
         m_have    = 1;
         m_held    = 0;
         m_pc      = pc_jump ? pc_target : m_next_pc;
         m_next_pc = m_pc + 32'd4;
      end else if (m_have) begin
         m_held = 1;
      end
   endtask

   task automatic drive(input bit r, input bit we, input bit st, input bit jp,
                        input logic [31:0] tg);
      rst = r; work_ena = we; stall = st; pc_jump = jp; pc_target = tg;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      model_reset();
      rst = 0; work_ena = 0; stall = 0; pc_jump = 0; pc_target = '0;
      rst8 = 0; work8 = 0; stall8 = 0; jump8 = 0; target8 = '0;
      tick();
      tick();

      // Narrow PC: jump to the top of the 8-bit space must wrap to zero.
      rst8 = 1; work8 = 1;
      @(negedge clk);
      chk("w8.idle_en", en8, 1'b0);
      tick();
      jump8 = 1; target8 = 8'hFC;
      @(negedge clk);
      chk("w8.jump_addr", addr8, 8'hFC);
      chk("w8.jump_kill", valid8, 1'b0);
      tick();
      jump8 = 0;
      @(negedge clk);
      chk("w8.pc_fc", pc8, 8'hFC);
      chk("w8.next_addr", addr8, 8'h00);
      tick();
      @(negedge clk);
      chk("w8.pc_wrap", pc8, 8'h00);
      chk("w8.instr_wrap", instr8, mem_word(32'h0));
      chk("w8.state", state8, 2'd1);
      rst8 = 0; work8 = 0;

      // Reset state.
      drive(0, 1, 0, 0, 0); check_all("rst");
      chk("rst.state0", state_o, 2'd0);
      tick();

      // Sequential fetch.
      drive(1, 1, 0, 0, 0); check_all("t1.c0"); chk("t1.idle", imem_en, 1'b0); tick();
      drive(1, 1, 0, 0, 0); check_all("t1.c1"); chk("t1.addr0", imem_addr, 32'h0); tick();
      drive(1, 1, 0, 0, 0); check_all("t1.c2"); chk("t1.pc0", pc_o, 32'h0); tick();
      drive(1, 1, 0, 0, 0); check_all("t1.c3"); chk("t1.pc4", pc_o, 32'h4); tick();

      // Three stall cycles while pc_o=8.
      drive(1, 1, 1, 0, 0); check_all("t2.s0"); chk("t2.pc8", pc_o, 32'h8); tick();
      drive(1, 1, 1, 0, 0); check_all("t2.s1"); chk("t2.hold", state_o, 2'd2); tick();
      drive(1, 1, 1, 0, 0); check_all("t2.s2"); chk("t2.noen", imem_en, 1'b0); tick();
      drive(1, 1, 0, 0, 0); check_all("t2.rel"); chk("t2.held8", pc_o, 32'h8); tick();
      drive(1, 1, 0, 0, 0); check_all("t2.nxt"); chk("t2.pcc", pc_o, 32'hC); tick();

      // Jump from RUN.
      drive(1, 1, 0, 1, 32'h100); check_all("t3.j"); chk("t3.kill", instr_valid, 1'b0); tick();
      drive(1, 1, 0, 0, 0); check_all("t3.t0"); chk("t3.pc100", pc_o, 32'h100); tick();
      drive(1, 1, 1, 0, 0); check_all("t3.t1"); chk("t3.pc104", pc_o, 32'h104); tick();

      // Jump from HOLD with stall still asserted.
      drive(1, 1, 1, 1, 32'h200); check_all("t4.j"); tick();
      drive(1, 1, 1, 0, 0); check_all("t4.t");
      chk("t4.pc200", pc_o, 32'h200); chk("t4.run", state_o, 2'd1); tick();

      // Drop work_ena, then re-enable.
      drive(1, 0, 0, 0, 0); check_all("t5.off"); chk("t5.kill", instr_valid, 1'b0); tick();
      drive(1, 0, 0, 0, 0); check_all("t5.idle"); chk("t5.st0", state_o, 2'd0); tick();
      drive(1, 1, 0, 0, 0); check_all("t5.on0"); tick();
      drive(1, 1, 0, 0, 0); check_all("t5.on1"); tick();
      drive(1, 1, 0, 0, 0); check_all("t5.on2"); chk("t5.pcrst", pc_o, 32'h0); tick();

      // Reset while holding.
      drive(1, 1, 1, 0, 0); check_all("t6.s"); tick();
      drive(0, 1, 1, 0, 0); check_all("t6.r"); chk("t6.hold", state_o, 2'd2); tick();
      drive(1, 1, 0, 0, 0); check_all("t6.after");
      chk("t6.valid0", instr_valid, 1'b0); chk("t6.pc0", pc_o, 32'h0); tick();

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] tg;
         tg = ($urandom % 5 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         drive(($urandom % 60) != 0, ($urandom % 12) != 0, ($urandom % 3) == 0,
               ($urandom % 7) == 0, tg);
         check_all("rnd");
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
